// File: rtl/dec_mac_scheduler_if.sv
// Request/grant and MAC sequencing bundle between the decimator stages, the
// scheduler and the shared coefficient ROM / MAC engine.
`timescale 1ns/1ps
interface dec_mac_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int TAPS    = 16
);
  localparam int TW = $clog2(TAPS);

  logic               enable_in;
  logic [NUM_REQ-1:0] req_in;
  logic               overrun_clr_in;
  logic [NUM_REQ-1:0] grant_out;
  logic [TW-1:0]      tap_idx_out;
  logic               mac_en_out;
  logic               mac_first_out;
  logic [NUM_REQ-1:0] done_out;
  logic [NUM_REQ-1:0] pending_out;
  logic [NUM_REQ-1:0] overrun_out;
  logic               busy_out;

  modport master (
    output enable_in, req_in, overrun_clr_in,
    input  grant_out, tap_idx_out, mac_en_out, mac_first_out,
    input  done_out, pending_out, overrun_out, busy_out
  );

  modport slave (
    input  enable_in, req_in, overrun_clr_in,
    output grant_out, tap_idx_out, mac_en_out, mac_first_out,
    output done_out, pending_out, overrun_out, busy_out
  );
endinterface

// File: rtl/dec_mac_scheduler.sv
// Round-robin scheduler time-sharing one MAC among NUM_REQ decimator stages:
// grants a stage, steps TAPS tap indices, drains the MAC pipeline, pulses done.
`timescale 1ns/1ps
module dec_mac_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TAPS    = 16,
  parameter int MAC_LAT = 2
) (
  input logic                clk_in,
  input logic                rst_in,
  dec_mac_scheduler_if.slave bus
);
  localparam int TW = $clog2(TAPS);
  localparam int PW = $clog2(NUM_REQ);
  localparam int FW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
  localparam logic [PW-1:0] PTR_RST    = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [PW-1:0]      ptr_r, ptr_nxt_s;
  logic [FW-1:0]      flush_r, flush_nxt_s;
  logic [NUM_REQ-1:0] pending_r, pending_nxt_s;
  logic [NUM_REQ-1:0] overrun_r, overrun_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [NUM_REQ-1:0] done_r, done_nxt_s;
  logic [TW-1:0]      tap_r, tap_nxt_s;
  logic               mac_en_r, mac_first_r, busy_r;
  logic [PW:0]        pick_s;
  logic [NUM_REQ-1:0] win_oh_s, grant_ev_s, ovr_ev_s;
  logic               fire_s;

  // First pending bit at or after ptr+1 (with wrap); MSB flags that one exists.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [PW-1:0]      ptr);
    logic [PW:0]   pick;
    logic [PW-1:0] idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = PW'((int'(ptr) + k) % NUM_REQ);
      pick = req[idx] ? {1'b1, idx} : pick;
    end
    return pick;
  endfunction

  assign pick_s   = rr_pick(pending_r, ptr_r);
  assign win_oh_s = NUM_REQ'(1'b1) << pick_s[PW-1:0];

  // Job sequencing: arbitration in IDLE, tap stepping, pipeline drain, done pulse.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    flush_nxt_s = flush_r;
    grant_nxt_s = grant_r;
    tap_nxt_s   = '0;
    done_nxt_s  = '0;
    fire_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_nxt_s = '0;
        if (bus.enable_in && pick_s[PW]) begin
          state_nxt_s = ST_RUN;
          grant_nxt_s = win_oh_s;
          ptr_nxt_s   = pick_s[PW-1:0];
          fire_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tap_r == TAP_LAST) begin
          flush_nxt_s = '0;
          if (MAC_LAT == 0) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = grant_r;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end else begin
          tap_nxt_s = tap_r + TW'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_r == FLUSH_LAST) begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = grant_r;
        end else begin
          flush_nxt_s = flush_r + FW'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // A request landing on a still-pending, not-just-granted bit is lost; new loss beats clear.
  assign grant_ev_s    = fire_s ? win_oh_s : '0;
  assign ovr_ev_s      = bus.req_in & pending_r & ~grant_ev_s;
  assign pending_nxt_s = (pending_r & ~grant_ev_s) | bus.req_in;
  assign overrun_nxt_s = (bus.overrun_clr_in ? '0 : overrun_r) | ovr_ev_s;

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      ptr_r       <= PTR_RST;
      flush_r     <= '0;
      pending_r   <= '0;
      overrun_r   <= '0;
      grant_r     <= '0;
      done_r      <= '0;
      tap_r       <= '0;
      mac_en_r    <= 1'b0;
      mac_first_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      flush_r     <= flush_nxt_s;
      pending_r   <= pending_nxt_s;
      overrun_r   <= overrun_nxt_s;
      grant_r     <= grant_nxt_s;
      done_r      <= done_nxt_s;
      tap_r       <= tap_nxt_s;
      mac_en_r    <= (state_nxt_s == ST_RUN);
      mac_first_r <= fire_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.grant_out     = grant_r;
  assign bus.tap_idx_out   = tap_r;
  assign bus.mac_en_out    = mac_en_r;
  assign bus.mac_first_out = mac_first_r;
  assign bus.done_out      = done_r;
  assign bus.pending_out   = pending_r;
  assign bus.overrun_out   = overrun_r;
  assign bus.busy_out      = busy_r;
endmodule

// File: tb/tb_dec_mac_scheduler.sv
// Bench for dec_mac_scheduler: directed vector table, fairness sequence, and random
// traffic checked every cycle against a job-timeline reference model.
`timescale 1ns/1ps
module tb_dec_mac_scheduler;
  localparam int NUM_REQ = 4;
  localparam int TAPS    = 16;
  localparam int MAC_LAT = 2;
  localparam int TW      = $clog2(TAPS);
  localparam int NVEC    = 35;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  dec_mac_scheduler_if #(.NUM_REQ(NUM_REQ), .TAPS(TAPS)) bus ();
  dec_mac_scheduler #(.NUM_REQ(NUM_REQ), .TAPS(TAPS), .MAC_LAT(MAC_LAT)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one job = owner plus age in cycles since its grant.
  logic       m_active;
  int         m_owner;
  int         m_age;
  int         m_ptr;
  logic [3:0] m_pend;
  logic [3:0] m_ovr;

  typedef struct {
    logic          rst;
    logic          en;
    logic [3:0]    req;
    logic          clr;
    int            skip;
    logic [3:0]    grant;
    logic [TW-1:0] tap;
    logic          mac_en;
    logic          first;
    logic [3:0]    done;
    logic [3:0]    pend;
    logic [3:0]    ovr;
    logic          busy;
  } vec_t;

  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] req,
                              input logic clr, input int skip, input logic [3:0] grant,
                              input int tap, input logic mac_en, input logic first,
                              input logic [3:0] done, input logic [3:0] pend,
                              input logic [3:0] ovr, input logic busy);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.clr = clr; v.skip = skip;
    v.grant = grant; v.tap = TW'(tap); v.mac_en = mac_en; v.first = first;
    v.done = done; v.pend = pend; v.ovr = ovr; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [3:0] req,
                            input logic clr);
    logic [3:0] gmask;
    logic [3:0] lost;
    logic       found;
    int         idx;
    gmask = 4'b0000;
    if (rst) begin
      m_active = 1'b0; m_owner = 0; m_age = 0;
      m_pend = 4'b0000; m_ovr = 4'b0000; m_ptr = NUM_REQ - 1;
    end else begin
      if (m_active) begin
        if (m_age == TAPS + MAC_LAT) m_active = 1'b0;
        else m_age++;
      end else if (en && m_pend != 4'b0000) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (!found && m_pend[idx]) begin
            found   = 1'b1;
            m_owner = idx;
          end
        end
        m_active = 1'b1;
        m_age    = 0;
        m_ptr    = m_owner;
        gmask[m_owner] = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        lost[i] = req[i] && m_pend[i] && !gmask[i];
        m_pend[i] = (m_pend[i] && !gmask[i]) || req[i];
      end
      if (clr) m_ovr = 4'b0000;
      m_ovr = m_ovr | lost;
    end
  endtask

  task automatic check_model();
    logic [3:0]    e_grant;
    logic [3:0]    e_done;
    logic [TW-1:0] e_tap;
    logic          e_en;
    logic          e_first;
    e_grant = m_active ? 4'(1 << m_owner) : 4'b0000;
    e_en    = m_active && (m_age < TAPS);
    e_tap   = e_en ? TW'(m_age) : '0;
    e_first = m_active && (m_age == 0);
    e_done  = (m_active && m_age == TAPS + MAC_LAT) ? e_grant : 4'b0000;
    chk("model.grant",   bus.grant_out,     e_grant);
    chk("model.tap",     bus.tap_idx_out,   e_tap);
    chk("model.mac_en",  bus.mac_en_out,    e_en);
    chk("model.first",   bus.mac_first_out, e_first);
    chk("model.done",    bus.done_out,      e_done);
    chk("model.pending", bus.pending_out,   m_pend);
    chk("model.overrun", bus.overrun_out,   m_ovr);
    chk("model.busy",    bus.busy_out,      m_active);
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step(rst_in, bus.enable_in, bus.req_in, bus.overrun_clr_in);
    #1;
    check_model();
    @(negedge clk_in);
  endtask

  initial begin
    int w;
    logic [3:0] exp_owner;

    rst_in = 1'b1; bus.enable_in = 1'b0; bus.req_in = '0; bus.overrun_clr_in = 1'b0;
    m_active = 1'b0; m_owner = 0; m_age = 0; m_ptr = NUM_REQ - 1;
    m_pend = 4'b0000; m_ovr = 4'b0000;

    //            rst  en  req     clr skip grant   tap en fst done    pend    ovr     busy
    tbl[0]  = mk(1'b1,1'b1,4'b0000,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b0);
    tbl[1]  = mk(1'b0,1'b1,4'b0001,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0001,4'b0000,1'b0);
    tbl[2]  = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0001, 0,1'b1,1'b1,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[3]  = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0001, 1,1'b1,1'b0,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[4]  = mk(1'b0,1'b1,4'b0000,1'b0,13,4'b0001,15,1'b1,1'b0,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[5]  = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0001, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[6]  = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0001, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[7]  = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0001, 0,1'b0,1'b0,4'b0001,4'b0000,4'b0000,1'b1);
    tbl[8]  = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b0);
    tbl[9]  = mk(1'b0,1'b1,4'b0110,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0110,4'b0000,1'b0);
    tbl[10] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0010, 0,1'b1,1'b1,4'b0000,4'b0100,4'b0000,1'b1);
    tbl[11] = mk(1'b0,1'b1,4'b0000,1'b0,17,4'b0010, 0,1'b0,1'b0,4'b0010,4'b0100,4'b0000,1'b1);
    tbl[12] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0100,4'b0000,1'b0);
    tbl[13] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0100, 0,1'b1,1'b1,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[14] = mk(1'b0,1'b1,4'b0000,1'b0,17,4'b0100, 0,1'b0,1'b0,4'b0100,4'b0000,4'b0000,1'b1);
    tbl[15] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b0);
    tbl[16] = mk(1'b0,1'b1,4'b0010,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0010,4'b0000,1'b0);
    tbl[17] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0010, 0,1'b1,1'b1,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[18] = mk(1'b0,1'b1,4'b0100,1'b0, 0,4'b0010, 1,1'b1,1'b0,4'b0000,4'b0100,4'b0000,1'b1);
    tbl[19] = mk(1'b0,1'b1,4'b0100,1'b0, 0,4'b0010, 2,1'b1,1'b0,4'b0000,4'b0100,4'b0100,1'b1);
    tbl[20] = mk(1'b0,1'b1,4'b0100,1'b1, 0,4'b0010, 3,1'b1,1'b0,4'b0000,4'b0100,4'b0100,1'b1);
    tbl[21] = mk(1'b0,1'b1,4'b0000,1'b1, 0,4'b0010, 4,1'b1,1'b0,4'b0000,4'b0100,4'b0000,1'b1);
    tbl[22] = mk(1'b0,1'b1,4'b0000,1'b0,13,4'b0010, 0,1'b0,1'b0,4'b0010,4'b0100,4'b0000,1'b1);
    tbl[23] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0100,4'b0000,1'b0);
    tbl[24] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0100, 0,1'b1,1'b1,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[25] = mk(1'b0,1'b1,4'b0000,1'b0,17,4'b0100, 0,1'b0,1'b0,4'b0100,4'b0000,4'b0000,1'b1);
    tbl[26] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b0);
    tbl[27] = mk(1'b0,1'b0,4'b0001,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0001,4'b0000,1'b0);
    tbl[28] = mk(1'b0,1'b0,4'b0000,1'b0, 3,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0001,4'b0000,1'b0);
    tbl[29] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0001, 0,1'b1,1'b1,4'b0000,4'b0000,4'b0000,1'b1);
    tbl[30] = mk(1'b0,1'b1,4'b0010,1'b0, 6,4'b0001, 7,1'b1,1'b0,4'b0000,4'b0010,4'b0000,1'b1);
    tbl[31] = mk(1'b1,1'b1,4'b0000,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b0);
    tbl[32] = mk(1'b0,1'b1,4'b0000,1'b0,20,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0000,4'b0000,1'b0);
    tbl[33] = mk(1'b0,1'b1,4'b0001,1'b0, 0,4'b0000, 0,1'b0,1'b0,4'b0000,4'b0001,4'b0000,1'b0);
    tbl[34] = mk(1'b0,1'b1,4'b0000,1'b0, 0,4'b0001, 0,1'b1,1'b1,4'b0000,4'b0000,4'b0000,1'b1);

    for (int i = 0; i < NVEC; i++) begin
      rst_in = tbl[i].rst; bus.enable_in = tbl[i].en;
      bus.req_in = tbl[i].req; bus.overrun_clr_in = tbl[i].clr;
      tick();
      rst_in = 1'b0; bus.req_in = '0; bus.overrun_clr_in = 1'b0;
      for (int s = 0; s < tbl[i].skip; s++) tick();
      chk($sformatf("tbl[%0d].grant", i),   bus.grant_out,     tbl[i].grant);
      chk($sformatf("tbl[%0d].tap", i),     bus.tap_idx_out,   tbl[i].tap);
      chk($sformatf("tbl[%0d].mac_en", i),  bus.mac_en_out,    tbl[i].mac_en);
      chk($sformatf("tbl[%0d].first", i),   bus.mac_first_out, tbl[i].first);
      chk($sformatf("tbl[%0d].done", i),    bus.done_out,      tbl[i].done);
      chk($sformatf("tbl[%0d].pending", i), bus.pending_out,   tbl[i].pend);
      chk($sformatf("tbl[%0d].overrun", i), bus.overrun_out,   tbl[i].ovr);
      chk($sformatf("tbl[%0d].busy", i),    bus.busy_out,      tbl[i].busy);
    end

    // Fairness: stages 0 and 3 re-request on each of their own done pulses.
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    bus.enable_in = 1'b1;
    bus.req_in = 4'b1001; tick(); bus.req_in = '0;
    for (int j = 0; j < 4; j++) begin
      exp_owner = (j % 2 == 0) ? 4'b0001 : 4'b1000;
      w = 0;
      while (bus.done_out == 4'b0000 && w < 100) begin
        tick();
        w++;
      end
      chk($sformatf("fair[%0d].done", j), bus.done_out, exp_owner);
      bus.req_in = exp_owner; tick(); bus.req_in = '0;
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      rst_in             = ($urandom_range(0, 299) == 0);
      bus.enable_in      = ($urandom_range(0, 9) != 0);
      bus.overrun_clr_in = ($urandom_range(0, 30) == 0);
      for (int b = 0; b < NUM_REQ; b++) bus.req_in[b] = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
